// File: rtl/pipe_pkg.sv
// Shared ID/EXE pipeline definitions: widths, ALU command encodings and the
// registered control/data bundle carried from ID into EXE.
package pipe_pkg;

    localparam int DATA_W = 32;
    localparam int REG_AW = 5;
    localparam int CMD_W  = 4;

    typedef enum logic [CMD_W-1:0] {
        CMD_NOP = 4'd0,
        CMD_ADD = 4'd1,
        CMD_SUB = 4'd2,
        CMD_AND = 4'd3,
        CMD_OR  = 4'd4,
        CMD_XOR = 4'd5,
        CMD_SLL = 4'd6,
        CMD_SRL = 4'd7
    } exe_cmd_e;

    typedef struct packed {
        logic              valid;
        logic              wb_en;
        logic              mem_r_en;
        logic              mem_w_en;
        logic [CMD_W-1:0]  exe_cmd;
        logic [DATA_W-1:0] pc;
        logic [DATA_W-1:0] val1;
        logic [DATA_W-1:0] val2;
        logic [DATA_W-1:0] st_val;
        logic [REG_AW-1:0] dest;
        logic [REG_AW-1:0] src1;
        logic [REG_AW-1:0] src2;
        logic              two_src;
    } id_exe_t;

    localparam id_exe_t BUBBLE = '0;

endpackage

// File: rtl/id_exe_stage_reg_if.sv
// ID->EXE stage bundle: pipeline control, ID-side fields, registered EXE-side
// copies and the load-use stall outputs.
interface id_exe_stage_reg_if #(parameter int CNT_W = 16);
    import pipe_pkg::*;

    logic              freeze;
    logic              flush;

    logic              id_valid;
    logic [DATA_W-1:0] id_pc;
    logic              id_wb_en;
    logic              id_mem_r_en;
    logic              id_mem_w_en;
    logic [CMD_W-1:0]  id_exe_cmd;
    logic [DATA_W-1:0] id_val1;
    logic [DATA_W-1:0] id_val2;
    logic [DATA_W-1:0] id_st_val;
    logic [REG_AW-1:0] id_dest;
    logic [REG_AW-1:0] id_src1;
    logic [REG_AW-1:0] id_src2;
    logic              id_two_src;

    logic              exe_valid;
    logic [DATA_W-1:0] exe_pc;
    logic              exe_wb_en;
    logic              exe_mem_r_en;
    logic              exe_mem_w_en;
    logic [CMD_W-1:0]  exe_exe_cmd;
    logic [DATA_W-1:0] exe_val1;
    logic [DATA_W-1:0] exe_val2;
    logic [DATA_W-1:0] exe_st_val;
    logic [REG_AW-1:0] exe_dest;
    logic [REG_AW-1:0] exe_src1;
    logic [REG_AW-1:0] exe_src2;
    logic              exe_two_src;

    logic              hazard_stall;
    logic [CNT_W-1:0]  stall_cnt;

    modport master (
        output freeze, flush,
        output id_valid, id_pc, id_wb_en, id_mem_r_en, id_mem_w_en, id_exe_cmd,
        output id_val1, id_val2, id_st_val, id_dest, id_src1, id_src2, id_two_src,
        input  exe_valid, exe_pc, exe_wb_en, exe_mem_r_en, exe_mem_w_en, exe_exe_cmd,
        input  exe_val1, exe_val2, exe_st_val, exe_dest, exe_src1, exe_src2, exe_two_src,
        input  hazard_stall, stall_cnt
    );

    modport slave (
        input  freeze, flush,
        input  id_valid, id_pc, id_wb_en, id_mem_r_en, id_mem_w_en, id_exe_cmd,
        input  id_val1, id_val2, id_st_val, id_dest, id_src1, id_src2, id_two_src,
        output exe_valid, exe_pc, exe_wb_en, exe_mem_r_en, exe_mem_w_en, exe_exe_cmd,
        output exe_val1, exe_val2, exe_st_val, exe_dest, exe_src1, exe_src2, exe_two_src,
        output hazard_stall, stall_cnt
    );

endinterface

// File: rtl/load_use_detect.sv
// Load-use hazard detect: a load in EXE whose destination is read by the
// instruction in ID forces one bubble.
module load_use_detect
    import pipe_pkg::*;
(
    input  logic              exe_valid,
    input  logic              exe_mem_r_en,
    input  logic [REG_AW-1:0] exe_dest,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_src1,
    input  logic [REG_AW-1:0] id_src2,
    input  logic              id_two_src,
    output logic              hazard_stall
);

    logic src1_hit;
    logic src2_hit;

    assign src1_hit = (id_src1 == exe_dest);
    // src2 only matters when it is a real read (R-type operand or store data)
    assign src2_hit = id_two_src & (id_src2 == exe_dest);

    assign hazard_stall = exe_valid & exe_mem_r_en & (exe_dest != '0) & id_valid &
                          (src1_hit | src2_hit);

endmodule

// File: rtl/id_exe_stage_reg.sv
// ID->EXE pipeline register with freeze/flush, load-use bubble insertion and
// a saturating count of inserted load-use bubbles.
module id_exe_stage_reg
    import pipe_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    id_exe_stage_reg_if.slave  bus
);

    id_exe_t          id_in;
    id_exe_t          exe_q;
    logic [CNT_W-1:0] cnt_q;
    logic             hazard;

    load_use_detect u_load_use_detect (
        .exe_valid    (exe_q.valid),
        .exe_mem_r_en (exe_q.mem_r_en),
        .exe_dest     (exe_q.dest),
        .id_valid     (bus.id_valid),
        .id_src1      (bus.id_src1),
        .id_src2      (bus.id_src2),
        .id_two_src   (bus.id_two_src),
        .hazard_stall (hazard)
    );

    // An invalid ID slot still carries its data but can never write or touch memory
    always_comb begin
        id_in          = BUBBLE;
        id_in.valid    = bus.id_valid;
        id_in.wb_en    = bus.id_valid & bus.id_wb_en;
        id_in.mem_r_en = bus.id_valid & bus.id_mem_r_en;
        id_in.mem_w_en = bus.id_valid & bus.id_mem_w_en;
        id_in.exe_cmd  = bus.id_exe_cmd;
        id_in.pc       = bus.id_pc;
        id_in.val1     = bus.id_val1;
        id_in.val2     = bus.id_val2;
        id_in.st_val   = bus.id_st_val;
        id_in.dest     = bus.id_dest;
        id_in.src1     = bus.id_src1;
        id_in.src2     = bus.id_src2;
        id_in.two_src  = bus.id_two_src;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            exe_q <= BUBBLE;
        end else if (bus.freeze) begin
            exe_q <= exe_q;
        end else if (bus.flush || hazard) begin
            exe_q <= BUBBLE;
        end else begin
            exe_q <= id_in;
        end
    end

    // Only bubbles actually inserted for load-use are counted; flush wins over hazard
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (!bus.freeze && !bus.flush && hazard && (cnt_q != '1)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign bus.exe_valid    = exe_q.valid;
    assign bus.exe_pc       = exe_q.pc;
    assign bus.exe_wb_en    = exe_q.wb_en;
    assign bus.exe_mem_r_en = exe_q.mem_r_en;
    assign bus.exe_mem_w_en = exe_q.mem_w_en;
    assign bus.exe_exe_cmd  = exe_q.exe_cmd;
    assign bus.exe_val1     = exe_q.val1;
    assign bus.exe_val2     = exe_q.val2;
    assign bus.exe_st_val   = exe_q.st_val;
    assign bus.exe_dest     = exe_q.dest;
    assign bus.exe_src1     = exe_q.src1;
    assign bus.exe_src2     = exe_q.src2;
    assign bus.exe_two_src  = exe_q.two_src;
    assign bus.hazard_stall = hazard;
    assign bus.stall_cnt    = cnt_q;

endmodule
